// File: rtl/producao_pkg.sv
// Shared types, constants and BCD helper for the corking-line counters.
package producao_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dez;
    bcd_t uni;
  } bcd2_t;

  localparam int BCD_MAX      = 9;
  localparam int DUZIA        = 12;
  localparam int CONTAGEM_MAX = 99;

  function automatic bcd2_t para_bcd(input logic [6:0] v);
    bcd2_t r;
    r.dez = bcd_t'(v / 7'd10);
    r.uni = bcd_t'(v % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_2dig.sv
// Two-digit BCD register: increment, floor-at-zero decrement and saturating add.
// proximo is the combinational next value so callers can derive registered flags.
module contador_bcd_2dig
  import producao_pkg::*;
#(
  parameter int INICIAL = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        dec,
  input  logic        add,
  input  logic [6:0]  add_val,
  output bcd2_t       valor,
  output bcd2_t       proximo
);

  localparam bcd2_t VALOR_RESET = para_bcd(7'(INICIAL));

  logic [7:0] atual;
  logic [7:0] soma;

  assign atual = {4'd0, valor.dez} * 8'd10 + {4'd0, valor.uni};

  always_comb begin
    soma = atual;
    if (dec && atual != 8'd0)
      soma = soma - 8'd1;
    if (inc)
      soma = soma + 8'd1;
    if (add)
      soma = soma + {1'b0, add_val};
    if (soma > 8'(CONTAGEM_MAX))
      soma = 8'(CONTAGEM_MAX);
    proximo = para_bcd(soma[6:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      valor <= VALOR_RESET;
    else
      valor <= proximo;
  end

endmodule

// File: rtl/contador_producao.sv
// Bottle-dozen and cork-stock BCD counters plus display scan index.
// Optional low-stock alert output when CONTADOR_ALERTA_EN is defined.
module contador_producao
  import producao_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int ROLHAS_INICIAL = 99,
  parameter int REPOSICAO      = 15
`ifdef CONTADOR_ALERTA_EN
  ,
  parameter int LIMIAR         = 10
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       garrafa_vedada,
  input  logic       repor_rolhas,
  input  logic       ligado,
  output logic [3:0] duzias_dezenas,
  output logic [3:0] duzias_unidades,
  output logic [3:0] rolhas_dezenas,
  output logic [3:0] rolhas_unidades,
  output logic [1:0] contador,
  output logic       sem_rolhas,
  output logic       duzias_cheio
`ifdef CONTADOR_ALERTA_EN
  ,
  output logic       rolhas_baixo
`endif
);

  localparam bcd2_t BCD_CHEIO = para_bcd(7'(CONTAGEM_MAX));

  logic        prev_g;
  logic        prev_r;
  logic        ev_g;
  logic        ev_r;
  logic        conta;
  logic        virada;
  logic [3:0]  garrafas;
  logic [15:0] presc;
  bcd2_t       rolhas;
  bcd2_t       rolhas_nxt;
  bcd2_t       duzias;
  bcd2_t       duzias_nxt;

  assign ev_g   = ligado & garrafa_vedada & ~prev_g;
  assign ev_r   = ligado & repor_rolhas & ~prev_r;
  // sem_rolhas always mirrors the registered stock being 00
  assign conta  = ev_g & ~sem_rolhas;
  assign virada = conta && garrafas == 4'(DUZIA - 1);

  contador_bcd_2dig #(
    .INICIAL (ROLHAS_INICIAL)
  ) u_rolhas (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (1'b0),
    .dec     (conta),
    .add     (ev_r),
    .add_val (7'(REPOSICAO)),
    .valor   (rolhas),
    .proximo (rolhas_nxt)
  );

  contador_bcd_2dig #(
    .INICIAL (0)
  ) u_duzias (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (virada),
    .dec     (1'b0),
    .add     (1'b0),
    .add_val (7'd0),
    .valor   (duzias),
    .proximo (duzias_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_g   <= 1'b0;
      prev_r   <= 1'b0;
      garrafas <= 4'd0;
    end else begin
      prev_g <= garrafa_vedada;
      prev_r <= repor_rolhas;
      if (conta)
        garrafas <= virada ? 4'd0 : garrafas + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sem_rolhas   <= 1'(ROLHAS_INICIAL == 0);
      duzias_cheio <= 1'b0;
    end else begin
      sem_rolhas   <= (rolhas_nxt == '0);
      duzias_cheio <= (duzias_nxt == BCD_CHEIO);
    end
  end

`ifdef CONTADOR_ALERTA_EN
  // packed BCD compares numerically, so no binary conversion needed
  localparam int    LIM_SAT = (LIMIAR > CONTAGEM_MAX) ? CONTAGEM_MAX : LIMIAR;
  localparam bcd2_t LIM_BCD = para_bcd(7'(LIM_SAT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      rolhas_baixo <= 1'(ROLHAS_INICIAL <= LIMIAR);
    else
      rolhas_baixo <= (rolhas_nxt <= LIM_BCD);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= 16'd0;
      contador <= 2'd0;
    end else if (presc == 16'(SCAN_DIV - 1)) begin
      presc    <= 16'd0;
      contador <= contador + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign duzias_dezenas  = duzias.dez;
  assign duzias_unidades = duzias.uni;
  assign rolhas_dezenas  = rolhas.dez;
  assign rolhas_unidades = rolhas.uni;

endmodule

// File: doc/contador_producao.md
# contador_producao

Upstream counting stage of the corking-line display path. Turns the sealed-bottle and cork-refill inputs into two-digit BCD counts: dozens of bottles completed, and corks remaining in stock. It also generates the 2-bit digit-scan index that drives the multiplexed 4-digit display stage downstream. All outputs are registered and feed the display stage directly.

## Interface
- `SCAN_DIV`, 1000: clock cycles each display digit stays selected, range 2..65535.
- `ROLHAS_INICIAL`, 99: cork stock loaded at reset, binary 0..99, converted to BCD at elaboration.
- `REPOSICAO`, 15: corks added per refill event, 1..99.
- `clock`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `garrafa_vedada`  in  1  synchronous level from the sealing sensor; its rising edge is one bottle sealed.
- `repor_rolhas`  in  1  synchronous level from the refill button; its rising edge is one refill.
- `ligado`  in  1  line enabled; when low, events are ignored.
- `duzias_dezenas`, `duzias_unidades`  out  4 each  BCD dozens completed, 00..99.
- `rolhas_dezenas`, `rolhas_unidades`  out  4 each  BCD corks in stock, 00..99.
- `contador`  out  2  digit-scan index, 0..3.
- `sem_rolhas`  out  1  high while cork stock is 00.
- `duzias_cheio`  out  1  high while the dozens count is 99.

## Operation
- **Edge detection.** `garrafa_vedada` and `repor_rolhas` each have a previous-value register, updated every cycle regardless of `ligado`. An event is `in & ~prev`. Holding an input high produces exactly one event.
- **Bottle event** (`ligado`=1 and `sem_rolhas`=0):
  - cork stock decrements by 1 in BCD; e.g. 10 becomes 09.
  - the internal bottle counter `garrafas` (binary, 0..11) increments.
  - when `garrafas` goes from 11 to 0, dozens increment in BCD; e.g. 09 becomes 10.
- **Bottle event with stock 00** is dropped: no change to stock, `garrafas` or dozens.
- **Dozens saturate at 99.** Further wraps leave the count at 99; `garrafas` keeps cycling 0..11.
- **Refill event** (`ligado`=1): stock = min(stock + `REPOSICAO`, 99).
- **Simultaneous bottle and refill events:** stock = min(stock − 1 + `REPOSICAO`, 99) when stock > 0, otherwise min(`REPOSICAO`, 99). The bottle counts only if the stock before the update was > 0.
- **`ligado`=0:** all events are ignored and counts hold.
- **Flags:** `sem_rolhas` and `duzias_cheio` are registered and computed from the next-state values, so they are valid in the same cycle as the counts.
- **Scan:**
  - the prescaler counts 0..`SCAN_DIV`−1 and then wraps.
  - `contador` increments on each wrap, 3→0.
  - scanning runs independently of `ligado`.
- **BCD rules:** digits never leave 0..9. Arithmetic is done per digit with borrow/carry, or in binary with a registered BCD conversion that adds no extra latency.

## Timing
- **Reset values:**
  - stock = BCD(`ROLHAS_INICIAL`)
  - dozens = 00, `garrafas` = 0
  - `contador` = 0, prescaler = 0
  - edge registers = 0
  - `sem_rolhas` = (`ROLHAS_INICIAL`==0), `duzias_cheio` = 0
- **Count latency:** an input first sampled high at edge N, with prev = 0, gives updated counts and flags after edge N. Latency is 1 clock and there is no combinational path from inputs to outputs.
- **Input high during reset release:** counts as an edge at the first active clock, because prev resets to 0.
- **Reset asserted mid-operation:** every register goes to its reset value immediately, without waiting for a clock.
- **Scan period:** after reset, `contador` first changes after edge `SCAN_DIV`. A full cycle through all 4 digits takes 4·`SCAN_DIV` clocks.

## Configuration
- `CONTADOR_ALERTA_EN`
  - **Defined:** adds parameter `LIMIAR` (default 10) and output `rolhas_baixo` (1 bit, registered, reset = (`ROLHAS_INICIAL` ≤ `LIMIAR`)). `rolhas_baixo` is high while stock ≤ `LIMIAR`, with the same latency as the counts.
  - **Undefined:** neither the port nor the logic exists; all other behaviour is identical.

## Structure
- **Shared package `producao_pkg`:**
  - BCD digit type (4 bits)
  - constants `BCD_MAX` = 9, `DUZIA` = 12, `CONTAGEM_MAX` = 99
  - function converting binary 0..99 to a BCD pair
- **Sub-module `contador_bcd_2dig`:** two-digit BCD register with increment, decrement and add-with-saturation inputs, and asynchronous active-low reset. It is instantiated twice, once for stock and once for dozens.

## Test plan
- **Reset:** release `reset_n` with defaults → stock 9/9, dozens 0/0, `contador`=0, `sem_rolhas`=0; `contador` is 1 after 1000 clocks and back to 0 after 4000.
- **First dozen:** 12 bottle pulses (each 3 cycles high) → stock 8/7, dozens 0/1; holding `garrafa_vedada` high for 50 cycles counts exactly 1 bottle.
- **Empty stock:** `ROLHAS_INICIAL`=2, then 3 bottle pulses → stock 0/0, `sem_rolhas`=1 after the 2nd pulse; the 3rd pulse leaves `garrafas` and dozens unchanged.
- **Refill and simultaneous events:** stock 90 plus a refill → 99; stock 05 with bottle and refill on the same edge → 19.
- **Dozens saturation:** preload dozens to 99 and send 12 bottle pulses → dozens stay 9/9, `duzias_cheio`=1, stock still decrements.
- **Disable and mid-operation reset:** with `ligado`=0, 5 pulses → counts unchanged; assert `reset_n` low between clock edges → outputs return to reset values immediately.
